// File: rtl/alu_pkg.sv
// Shared opcode, ALU select and sequencer state definitions for the accumulator sequencer.
// Opcodes 000-100 double as the ALU select encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_MOD  = 3'b100,
        OP_LOAD = 3'b101,
        OP_READ = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    localparam logic [2:0] SEL_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_divide(input op_e op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_acc_seq.sv
// Accumulator sequencer feeding an external combinational ALU: one command per handshake,
// ALU result written back to the accumulator, registered response with zero/error flags.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a command; captures op/operand on handshake
// EXEC  | one cycle, ALU driven with acc/operand, accumulator and flags updated
// RESP  | out_valid=1, response held stable until out_ready
module alu_acc_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_operand,
    output logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_err,
    output logic             err_sticky
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       alu_sel_q, alu_sel_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        operand_d   = operand_q;
        acc_d       = acc_q;
        zero_d      = zero_q;
        err_d       = err_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        alu_sel_d   = alu_sel_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d      = op_e'(in_op);
                    operand_d = in_operand;
                    // Select is registered so the ALU sees the opcode exactly during EXEC.
                    alu_sel_d = is_arith(op_e'(in_op)) ? in_op : SEL_PASS;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                alu_sel_d   = SEL_PASS;
                out_valid_d = 1'b1;
                err_d       = 1'b0;
                state_d     = RESP;
                if (is_arith(op_q)) begin
                    if (is_divide(op_q) && (operand_q == '0)) begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        zero_d   = (acc_q == '0);
                    end else begin
                        acc_d  = alu_c;
                        zero_d = alu_z;
                    end
                end else begin
                    unique case (op_q)
                        OP_LOAD: begin
                            acc_d  = operand_q;
                            zero_d = (operand_q == '0);
                        end
                        OP_CLR: begin
                            acc_d    = '0;
                            zero_d   = 1'b1;
                            sticky_d = 1'b0;
                        end
                        default: zero_d = (acc_q == '0);
                    endcase
                end
            end
            RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                alu_sel_d   = SEL_PASS;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            operand_q   <= '0;
            acc_q       <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            alu_sel_q   <= SEL_PASS;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            operand_q   <= operand_d;
            acc_q       <= acc_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            alu_sel_q   <= alu_sel_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign alu_sel    = alu_sel_q;
    assign alu_a      = acc_q;
    assign alu_b      = operand_q;
    assign out_valid  = out_valid_q;
    assign out_result = acc_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Self-checking bench for alu_acc_seq: behavioural ALU beside the DUT, directed scenarios
// followed by randomized commands checked against an integer accumulator model.
module tb_alu_acc_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_operand;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_c;
    logic         alu_z;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_err;
    logic         err_sticky;

    int n_tests = 0;
    int n_fail  = 0;
    int m_acc    = 0;
    int m_sticky = 0;

    always #5 clk = ~clk;

    alu_acc_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_operand (in_operand),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err),
        .err_sticky (err_sticky)
    );

    // Stand-in for the team's combinational ALU.
    int alu_ai, alu_bi, alu_ri;
    always_comb begin
        alu_ai = int'($signed(alu_a));
        alu_bi = int'($signed(alu_b));
        alu_ri = alu_ai;
        case (alu_sel)
            3'd0: alu_ri = alu_ai + alu_bi;
            3'd1: alu_ri = alu_ai - alu_bi;
            3'd2: alu_ri = alu_ai * alu_bi;
            3'd3: alu_ri = (alu_bi == 0) ? 0 : alu_ai / alu_bi;
            3'd4: alu_ri = (alu_bi == 0) ? 0 : alu_ai % alu_bi;
            default: alu_ri = alu_ai;
        endcase
        alu_c = W'(alu_ri);
        alu_z = (W'(alu_ri) == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int wrap(input int x);
        int m;
        m = x & 255;
        return (m >= 128) ? m - 256 : m;
    endfunction

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model(input logic [2:0] op, input int opd,
                         output int res, output int zero, output int err);
        err = 0;
        res = m_acc;
        case (op)
            3'd0: res = wrap(m_acc + opd);
            3'd1: res = wrap(m_acc - opd);
            3'd2: res = wrap(m_acc * opd);
            3'd3: if (opd == 0) err = 1; else res = wrap(m_acc / opd);
            3'd4: if (opd == 0) err = 1; else res = wrap(m_acc % opd);
            3'd5: res = opd;
            3'd6: res = m_acc;
            default: begin
                res = 0;
                m_sticky = 0;
            end
        endcase
        if (err == 1) m_sticky = 1;
        m_acc = res;
        zero = (res == 0) ? 1 : 0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input int opd, input int stall);
        int er, ez, ee, prev_acc;
        logic [2:0] es;
        prev_acc = m_acc;
        model(op, opd, er, ez, ee);
        es = (op <= 3'd4) ? op : 3'b111;
        @(negedge clk);
        in_valid   = 1'b1;
        in_op      = op;
        in_operand = W'(opd);
        out_ready  = 1'b0;
        check("idle_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_op      = 3'($urandom);
        in_operand = W'($urandom);
        check("exec_out_valid", 32'(out_valid), 0);
        check("exec_in_ready", 32'(in_ready), 0);
        check("exec_alu_sel", 32'(alu_sel), 32'(es));
        check("exec_alu_a", sx(alu_a), prev_acc);
        check("exec_alu_b", sx(alu_b), wrap(opd));
        @(posedge clk); #1;
        check("resp_out_valid", 32'(out_valid), 1);
        check("resp_result", sx(out_result), er);
        check("resp_zero", 32'(out_zero), ez);
        check("resp_err", 32'(out_err), ee);
        check("resp_sticky", 32'(err_sticky), m_sticky);
        check("resp_alu_sel", 32'(alu_sel), 3'b111);
        for (int i = 0; i < stall; i++) begin
            in_valid   = 1'b1;
            in_op      = 3'($urandom);
            in_operand = W'($urandom);
            @(posedge clk); #1;
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_result", sx(out_result), er);
            check("stall_err", 32'(out_err), ee);
            check("stall_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("done_out_valid", 32'(out_valid), 0);
        check("done_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        int r, opd;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_op      = 3'd5;
        in_operand = 8'd9;
        out_ready  = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_alu_sel", 32'(alu_sel), 3'b111);
        check("rst_sticky", 32'(err_sticky), 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ignore_valid", 32'(out_valid), 0);
        check("rst_acc", sx(alu_a), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;

        // Plan 1-3, 6
        run_cmd(3'd5, 5, 0);
        run_cmd(3'd0, 3, 0);
        run_cmd(3'd5, 127, 0);
        run_cmd(3'd0, 1, 0);
        run_cmd(3'd5, -3, 0);
        run_cmd(3'd2, 7, 0);
        run_cmd(3'd5, -20, 0);
        run_cmd(3'd3, 6, 0);
        run_cmd(3'd5, 20, 0);
        run_cmd(3'd3, 0, 0);
        run_cmd(3'd4, -6, 0);
        run_cmd(3'd7, 0, 0);
        run_cmd(3'd5, -128, 0);
        run_cmd(3'd3, -1, 0);
        run_cmd(3'd5, -7, 0);
        run_cmd(3'd1, -7, 0);
        run_cmd(3'd6, 0, 0);
        // Backpressure with a pending command held on the input
        run_cmd(3'd5, 42, 5);
        run_cmd(3'd6, 0, 0);

        // Reset during EXEC, with err_sticky set beforehand
        run_cmd(3'd4, 0, 0);
        @(negedge clk);
        in_valid   = 1'b1;
        in_op      = 3'd0;
        in_operand = 8'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midop_alu_sel", 32'(alu_sel), 0);
        rst = 1'b1;
        #1;
        check("midop_out_valid", 32'(out_valid), 0);
        check("midop_sticky", 32'(err_sticky), 0);
        check("midop_alu_sel_rst", 32'(alu_sel), 3'b111);
        @(posedge clk); #1;
        check("midop_no_resp", 32'(out_valid), 0);
        @(negedge clk);
        rst      = 1'b0;
        m_acc    = 0;
        m_sticky = 0;
        run_cmd(3'd6, 0, 0);

        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0: opd = 0;
                1: opd = -1;
                2: opd = -128;
                3: opd = 127;
                default: opd = int'($urandom_range(0, 255)) - 128;
            endcase
            run_cmd(3'($urandom_range(0, 7)), opd, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
